operand_fetch: RTL



---
 rtl/operand_fetch_if.sv | 43 ++++
 rtl/operand_fetch.sv | 125 ++++++++++++
 2 files changed

// File: rtl/operand_fetch_if.sv
// ============================================================================
//  Module      : operand_fetch_if
//  Description : Handshake and bus bundle for the operand_fetch block.
//                Carries the fetch request, the operand hand-off to the
//                shifter/ALU, and the register-file writeback port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface operand_fetch_if #(
    parameter int DATA_W = 16
);
    // fetch request
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        rd_a;
    logic [2:0]        rd_b;
    logic [1:0]        shift_in;
    // operand hand-off
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] a_out;
    logic [DATA_W-1:0] b_out;
    logic [1:0]        shift_out;
    // writeback
    logic              wr_en;
    logic [2:0]        wr_num;
    logic [DATA_W-1:0] wr_data;

    // requester / writeback / consumer side
    modport master (
        output req_valid, rd_a, rd_b, shift_in, op_ready, wr_en, wr_num, wr_data,
        input  req_ready, op_valid, a_out, b_out, shift_out
    );

    // operand_fetch side
    modport slave (
        input  req_valid, rd_a, rd_b, shift_in, op_ready, wr_en, wr_num, wr_data,
        output req_ready, op_valid, a_out, b_out, shift_out
    );
endinterface

`default_nettype wire

// File: rtl/operand_fetch.sv
// ============================================================================
//  Module      : operand_fetch
//  Description : Eight-entry register file plus operand staging for the
//                shifter/ALU. A fetch reads R[rd_a] then R[rd_b] into the
//                A/B operand registers and holds them under valid/ready.
//                Writeback updates the register file on any cycle.
//  Options     : OPFETCH_BYPASS_EN - forward same-edge writeback data into
//                the operand register being loaded (write-to-read bypass).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_fetch #(
    parameter int DATA_W  = 16,
    parameter int REG_CNT = 8
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    operand_fetch_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ_A = 2'd1,
        ST_READ_B = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_regs [REG_CNT];
    logic [2:0]        r_rd_a;
    logic [2:0]        r_rd_b;
    logic [1:0]        r_shift;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_op_valid;
    logic              r_req_ready;

    logic [2:0]        w_rd_idx;
    logic [DATA_W-1:0] w_rd_data;

    // One shared read port: READ_A uses the latched A index, otherwise B.
    assign w_rd_idx = (r_state == ST_READ_A) ? r_rd_a : r_rd_b;

`ifdef OPFETCH_BYPASS_EN
    // Read port with same-edge writeback forwarded into the operand.
    always_comb begin
        w_rd_data = r_regs[w_rd_idx];
        if (bus.wr_en && (bus.wr_num == w_rd_idx)) begin
            w_rd_data = bus.wr_data;
        end
    end
`else
    // Without forwarding a colliding read sees the pre-write contents.
    assign w_rd_data = r_regs[w_rd_idx];
`endif

    // Register file: writeback is independent of the fetch sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_CNT; i++) begin
                r_regs[i] <= '0;
            end
        end else if (bus.wr_en) begin
            r_regs[bus.wr_num] <= bus.wr_data;
        end
    end

    // Fetch sequencer with registered handshake outputs; operands are only
    // written in READ_A/READ_B so they stay frozen throughout HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rd_a      <= '0;
            r_rd_b      <= '0;
            r_shift     <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_op_valid  <= 1'b0;
            r_req_ready <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_rd_a      <= bus.rd_a;
                        r_rd_b      <= bus.rd_b;
                        r_shift     <= bus.shift_in;
                        r_req_ready <= 1'b0;
                        r_state     <= ST_READ_A;
                    end
                end
                ST_READ_A: begin
                    r_a     <= w_rd_data;
                    r_state <= ST_READ_B;
                end
                ST_READ_B: begin
                    r_b        <= w_rd_data;
                    r_op_valid <= 1'b1;
                    r_state    <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.op_ready) begin
                        r_op_valid  <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_op_valid  <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.op_valid  = r_op_valid;
    assign bus.a_out     = r_a;
    assign bus.b_out     = r_b;
    assign bus.shift_out = r_shift;

endmodule

`default_nettype wire
